clock_chain_ctrl: RTL and testbench

- Sequencer for six cascaded c74160-style BCD decade counters forming an HH:MM:SS timekeeper.
- Drives each digit's count enable, active-low load and load data. Handles mod-6 tens digits, the 23:59:59→00:00:00 rollover and a button-driven time-set mode.
- Sits between the 1 Hz prescaler / button synchronizers and the counter chain. Digit values are fed back to it.

---
 rtl/clock_chain_ctrl.sv | 155 +++++++++++++++
 tb/tb_clock_chain_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_chain_ctrl.sv
// Sequencer for six cascaded BCD decade counters forming an HH:MM:SS clock.
// Issues registered single-cycle enable/load pulses for the run and time-set modes.
module clock_chain_ctrl #(
  parameter logic [3:0] HR_WRAP_TENS = 4'd2,
  parameter logic [3:0] HR_WRAP_ONES = 4'd3
) (
  input  logic        clk,
  input  logic        notMr,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] digit_q,
  output logic [5:0]  cnt_en,
  output logic [5:0]  cnt_load_n,
  output logic [23:0] cnt_d,
  output logic [1:0]  mode,
  output logic        blink
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  localparam int S1  = 0;
  localparam int S10 = 1;
  localparam int M1  = 2;
  localparam int M10 = 3;
  localparam int H1  = 4;
  localparam int H10 = 5;

  mode_e       mode_q, mode_d;
  logic [5:0]  cnt_en_q, cnt_en_d;
  logic [5:0]  cnt_load_n_q, cnt_load_n_d;
  logic [23:0] cnt_d_q, cnt_d_d;
  logic        blink_q, blink_d;
  logic        mode_hist_q, mode_hist_d;
  logic        inc_hist_q, inc_hist_d;
  logic        pending_q, pending_d;

  logic [3:0] h10, h1, m10, m1, s10, s1;
  logic       c0, c1, c2, c3, hw;
  logic       mode_evt, inc_evt;

  assign {h10, h1, m10, m1, s10, s1} = digit_q;

  assign c0 = (s1 == 4'd9);
  assign c1 = c0 & (s10 == 4'd5);
  assign c2 = c1 & (m1 == 4'd9);
  assign c3 = c2 & (m10 == 4'd5);
  assign hw = (h10 == HR_WRAP_TENS) & (h1 == HR_WRAP_ONES);

  assign mode_evt = btn_mode & ~mode_hist_q;
  assign inc_evt  = btn_inc & ~inc_hist_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    mode_d       = mode_q;
    blink_d      = blink_q;
    cnt_en_d     = '0;
    cnt_load_n_d = '1;
    cnt_d_d      = '0;
    mode_hist_d  = btn_mode;
    inc_hist_d   = btn_inc;

    // While a pulse is at the counters the feedback is stale; drop all events.
    if (!pending_q) begin
      if (mode_evt) begin
        case (mode_q)
          RUN: begin
            mode_d            = SET_HR;
            cnt_load_n_d[S1]  = 1'b0;
            cnt_load_n_d[S10] = 1'b0;
          end
          SET_HR:  mode_d = SET_MIN;
          default: mode_d = RUN;
        endcase
      end else if (inc_evt && mode_q != RUN) begin
        if (mode_q == SET_HR) begin
          if (hw) begin
            cnt_load_n_d[H1]  = 1'b0;
            cnt_load_n_d[H10] = 1'b0;
          end else if (h1 == 4'd9) begin
            cnt_en_d[H1]  = 1'b1;
            cnt_en_d[H10] = 1'b1;
          end else begin
            cnt_en_d[H1] = 1'b1;
          end
        end else if (mode_q == SET_MIN) begin
          if (m10 == 4'd5 && m1 == 4'd9) begin
            cnt_load_n_d[M1]  = 1'b0;
            cnt_load_n_d[M10] = 1'b0;
          end else if (m1 == 4'd9) begin
            cnt_en_d[M1]  = 1'b1;
            cnt_en_d[M10] = 1'b1;
          end else begin
            cnt_en_d[M1] = 1'b1;
          end
        end
      end else if (tick) begin
        if (mode_q == RUN) begin
          cnt_en_d[S1] = 1'b1;
          if (c1)      cnt_load_n_d[S10] = 1'b0;
          else if (c0) cnt_en_d[S10]     = 1'b1;
          cnt_en_d[M1] = c1;
          if (c3)      cnt_load_n_d[M10] = 1'b0;
          else if (c2) cnt_en_d[M10]     = 1'b1;
          if (c3 && hw) begin
            cnt_load_n_d[H1]  = 1'b0;
            cnt_load_n_d[H10] = 1'b0;
          end else if (c3) begin
            cnt_en_d[H1] = 1'b1;
            if (h1 == 4'd9) cnt_en_d[H10] = 1'b1;
          end
        end else begin
          blink_d = ~blink_q;
        end
      end
    end

    if (mode_d == RUN) blink_d = 1'b0;
    pending_d = (|cnt_en_d) | ~(&cnt_load_n_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge notMr) begin
    if (!notMr) begin
      mode_q       <= RUN;
      cnt_en_q     <= '0;
      cnt_load_n_q <= '1;
      cnt_d_q      <= '0;
      blink_q      <= 1'b0;
      mode_hist_q  <= 1'b0;
      inc_hist_q   <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cnt_en_q     <= cnt_en_d;
      cnt_load_n_q <= cnt_load_n_d;
      cnt_d_q      <= cnt_d_d;
      blink_q      <= blink_d;
      mode_hist_q  <= mode_hist_d;
      inc_hist_q   <= inc_hist_d;
      pending_q    <= pending_d;
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_load_n = cnt_load_n_q;
  assign cnt_d      = cnt_d_q;
  assign mode       = mode_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_clock_chain_ctrl.sv
// Self-checking bench for clock_chain_ctrl: a behavioural time model feeds a scoreboard,
// and a c74160-style counter model closes the digit feedback loop.
module tb_clock_chain_ctrl;

  typedef struct packed {
    logic [5:0]  en;
    logic [5:0]  ln;
    logic [23:0] d;
    logic [1:0]  mode;
    logic        blink;
  } exp_t;

  logic        clk;
  logic        notMr;
  logic        tick;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] digit_q;
  logic [5:0]  cnt_en;
  logic [5:0]  cnt_load_n;
  logic [23:0] cnt_d;
  logic [1:0]  mode;
  logic        blink;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  // Reference model state
  int   m_mode;
  logic m_blink, m_pend, m_pm, m_pi;

  clock_chain_ctrl #(.HR_WRAP_TENS(4'd2), .HR_WRAP_ONES(4'd3)) dut (
    .clk        (clk),
    .notMr      (notMr),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .digit_q    (digit_q),
    .cnt_en     (cnt_en),
    .cnt_load_n (cnt_load_n),
    .cnt_d      (cnt_d),
    .mode       (mode),
    .blink      (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int d2s(input logic [23:0] d);
    return 36000 * int'(d[23:20]) + 3600 * int'(d[19:16]) + 600 * int'(d[15:12])
         + 60 * int'(d[11:8]) + 10 * int'(d[7:4]) + int'(d[3:0]);
  endfunction

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    logic [23:0] r;
    r[23:20] = 4'(h / 10); r[19:16] = 4'(h % 10);
    r[15:12] = 4'(m / 10); r[11:8]  = 4'(m % 10);
    r[7:4]   = 4'(s / 10); r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  function automatic logic [23:0] s2d(input int n);
    return hms(n / 3600, (n / 60) % 60, n % 60);
  endfunction

  // Command needed to move the counters from o to n: natural +1 or 9->0 uses enable, else load 0.
  function automatic void derive(input logic [23:0] o, input logic [23:0] n,
                                 output logic [5:0] en, output logic [5:0] ln);
    logic [3:0] a, b;
    en = '0;
    ln = '1;
    for (int k = 0; k < 6; k++) begin
      a = o[4*k +: 4];
      b = n[4*k +: 4];
      if (a != b) begin
        if (b == a + 4'd1 || (a == 4'd9 && b == 4'd0)) en[k] = 1'b1;
        else                                           ln[k] = 1'b0;
      end
    end
  endfunction

  // c74160 behaviour: load wins over enable, digits above 9 recover to 0.
  function automatic logic [23:0] cnt_next(input logic [23:0] cur, input logic [5:0] en,
                                           input logic [5:0] ln, input logic [23:0] ld);
    logic [23:0] r;
    r = cur;
    for (int k = 0; k < 6; k++) begin
      if (!ln[k])     r[4*k +: 4] = ld[4*k +: 4];
      else if (en[k]) r[4*k +: 4] = (cur[4*k +: 4] >= 4'd9) ? 4'd0 : cur[4*k +: 4] + 4'd1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_blink = 1'b0; m_pend = 1'b0; m_pm = 1'b0; m_pi = 1'b0;
  endtask

  task automatic model_eval(output exp_t e);
    logic        mode_evt, inc_evt;
    logic [23:0] nt;
    int          hh, mm, ss, t;
    mode_evt = btn_mode & ~m_pm;
    inc_evt  = btn_inc & ~m_pi;
    m_pm = btn_mode;
    m_pi = btn_inc;
    e.en = '0; e.ln = '1; e.d = '0;
    t  = d2s(digit_q);
    hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
    if (!m_pend) begin
      if (mode_evt) begin
        if (m_mode == 0) begin
          m_mode = 1;
          e.ln   = 6'b111100;
        end else if (m_mode == 1) m_mode = 2;
        else                      m_mode = 0;
      end else if (inc_evt && m_mode != 0) begin
        if (m_mode == 1) begin
          nt = hms((hh + 1) % 24, mm, ss);
          derive(digit_q, nt, e.en, e.ln);
        end else if ((mm + 1) % 60 == 0) begin
          e.ln = 6'b110011;
        end else begin
          nt = hms(hh, mm + 1, ss);
          derive(digit_q, nt, e.en, e.ln);
        end
      end else if (tick) begin
        if (m_mode == 0) derive(digit_q, s2d((t + 1) % 86400), e.en, e.ln);
        else             m_blink = ~m_blink;
      end
    end
    if (m_mode == 0) m_blink = 1'b0;
    m_pend  = (|e.en) | ~(&e.ln);
    e.mode  = 2'(m_mode);
    e.blink = m_blink;
  endtask

  // One clock: drive inputs, predict, let counters act on current outputs, compare after edge.
  task automatic step(input logic t, input logic m, input logic i);
    exp_t        e;
    logic [23:0] nxt;
    tick = t; btn_mode = m; btn_inc = i;
    model_eval(e);
    sb.push_back(e);
    nxt = cnt_next(digit_q, cnt_en, cnt_load_n, cnt_d);
    @(posedge clk);
    #1;
    digit_q = nxt;
    tick    = 1'b0;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("cnt_en", 32'(cnt_en), 32'(e.en));
      check("cnt_load_n", 32'(cnt_load_n), 32'(e.ln));
      check("cnt_d", 32'(cnt_d), 32'(e.d));
      check("mode", 32'(mode), 32'(e.mode));
      check("blink", 32'(blink), 32'(e.blink));
      check("en_load_overlap", 32'(cnt_en & ~cnt_load_n), 32'd0);
    end
  endtask

  task automatic tick_once();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_inc();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    digit_q = hms(h, m, s);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check(tag, 32'(digit_q), 32'(hms(h, m, s)));
  endtask

  initial begin
    int rh, rm, rs, rt;
    n_checks = 0;
    n_fail   = 0;
    notMr    = 1'b0;
    tick     = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    digit_q  = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt_en", 32'(cnt_en), 32'h00);
    check("rst_cnt_load_n", 32'(cnt_load_n), 32'h3f);
    check("rst_cnt_d", 32'(cnt_d), 32'h0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    notMr = 1'b1;

    // Run-mode carries and rollovers
    set_time(0, 0, 0);   tick_once(); check_time("run_00_00_00", 0, 0, 1);
    set_time(12, 59, 59); tick_once(); check_time("run_12_59_59", 13, 0, 0);
    set_time(23, 59, 59); tick_once(); check_time("run_23_59_59", 0, 0, 0);
    set_time(19, 59, 59); tick_once(); check_time("run_19_59_59", 20, 0, 0);
    set_time(9, 9, 49);   tick_once(); check_time("run_09_09_49", 9, 9, 50);

    // Tick and inc edge together in RUN: tick served, inc ignored
    set_time(0, 0, 5);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_time("tick_with_inc", 0, 0, 6);

    // Tick during the pending cycle is dropped
    set_time(0, 0, 10);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_time("pending_drop", 0, 0, 11);

    // Hour setting
    set_time(23, 45, 37);
    press_mode();           check_time("enter_set_hr", 23, 45, 0);
    press_inc();            check_time("set_hr_wrap", 0, 45, 0);
    set_time(9, 45, 0);
    press_inc();            check_time("set_hr_09", 10, 45, 0);
    press_inc();            check_time("set_hr_10", 11, 45, 0);
    tick_once();
    tick_once();
    tick_once();            check_time("set_hr_ticks", 11, 45, 0);

    // Minute setting, then back to RUN
    press_mode();
    set_time(11, 59, 0);
    press_inc();            check_time("set_min_wrap", 11, 0, 0);
    press_inc();            check_time("set_min_00", 11, 1, 0);
    set_time(11, 9, 0);
    press_inc();            check_time("set_min_09", 11, 10, 0);
    tick_once();
    press_mode();
    tick_once();            check_time("resume_run", 11, 10, 1);

    // Random legal times in RUN
    for (int n = 0; n < 30; n++) begin
      rh = int'($urandom_range(23, 0));
      rm = int'($urandom_range(59, 0));
      rs = (n % 3 == 0) ? 59 : int'($urandom_range(59, 0));
      if (n % 5 == 0) rm = 59;
      rt = (rh * 3600 + rm * 60 + rs + 1) % 86400;
      set_time(rh, rm, rs);
      tick_once();
      check_time("run_random", rt / 3600, (rt / 60) % 60, rt % 60);
    end

    // Asynchronous reset while a pulse is at the counters
    set_time(0, 0, 20);
    step(1'b1, 1'b0, 1'b0);
    notMr = 1'b0;
    #1;
    check("midrst_cnt_en", 32'(cnt_en), 32'h00);
    check("midrst_cnt_load_n", 32'(cnt_load_n), 32'h3f);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_blink", 32'(blink), 32'd0);
    sb.delete();
    model_reset();
    @(negedge clk);
    notMr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check_time("midrst_abandoned", 0, 0, 20);
    tick_once();
    check_time("midrst_resume", 0, 0, 21);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
